// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default divider settings and a
// parity helper, common to the receiver and the transmitter.
package uart_pkg;

    localparam int UART_CLK_DIVIDER   = 10417;
    localparam int UART_NBITS_DIVIDER = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit that accompanies 'data' (odd = 1'b0 gives even parity).
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a parameterised
// reset value so idle-high and idle-low lines can both use it.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next-state of the two capture stages.
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Capture stages, forced to the idle level on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first; define UART_RX_PARITY_EN for 8E1/8O1 with an
// o_parityErr strobe. CLK_DIVIDER must be >= 4 and fit in NBITS_DIVIDER bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIVIDER   = UART_CLK_DIVIDER,
    parameter int NBITS_DIVIDER = UART_NBITS_DIVIDER
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD    = 1'b0
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_serialRX,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frameErr
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parityErr
`endif
);

    localparam logic [NBITS_DIVIDER-1:0] CNT_ZERO     = NBITS_DIVIDER'(0);
    localparam logic [NBITS_DIVIDER-1:0] CNT_ONE      = NBITS_DIVIDER'(1);
    localparam logic [NBITS_DIVIDER-1:0] CNT_BIT_MAX  = NBITS_DIVIDER'(CLK_DIVIDER - 1);
    localparam logic [NBITS_DIVIDER-1:0] CNT_HALF_MAX = NBITS_DIVIDER'(CLK_DIVIDER / 2 - 1);

    logic                     rx_s;
    logic                     half_done_s;
    logic                     bit_done_s;

    uart_state_e              state_d;
    uart_state_e              state_q;
    logic [NBITS_DIVIDER-1:0] cnt_d;
    logic [NBITS_DIVIDER-1:0] cnt_q;
    logic [2:0]               idx_d;
    logic [2:0]               idx_q;
    logic [7:0]               shift_d;
    logic [7:0]               shift_q;
    logic [7:0]               data_d;
    logic [7:0]               data_q;
    logic                     valid_d;
    logic                     valid_q;
    logic                     busy_d;
    logic                     busy_q;
    logic                     ferr_d;
    logic                     ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                     par_d;
    logic                     par_q;
    logic                     perr_d;
    logic                     perr_q;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_serialRX),
        .o_q   (rx_s)
    );

    assign half_done_s = (cnt_q == CNT_HALF_MAX);
    assign bit_done_s  = (cnt_q == CNT_BIT_MAX);

    // Frame FSM: bit timing, sampling, and registered strobe generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (rx_s == 1'b0) begin
                    state_d = ST_START;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Half a bit period lands the later samples mid-bit.
            ST_START: begin
                if (half_done_s) begin
                    cnt_d = CNT_ZERO;
                    if (rx_s == 1'b0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bit_done_s) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    cnt_d   = CNT_ZERO;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif

            // Leaving at mid stop bit leaves half a bit to spot the next start.
            ST_STOP: begin
                if (bit_done_s) begin
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (rx_s == 1'b1) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (par_q != parity_bit(shift_q, PARITY_ODD));
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_frameErr = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parityErr = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a monitor pops
// and compares on every o_valid / o_frameErr strobe.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV = 16;
    localparam int NB  = 5;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + DIV / 2 + 10 * DIV + 1;
`else
    localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frameErr;
`ifdef UART_RX_PARITY_EN
    logic       o_parityErr;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_DIVIDER   (DIV),
        .NBITS_DIVIDER (NB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_serialRX  (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frameErr  (o_frameErr)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parityErr (o_parityErr)
`endif
    );

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        logic       perr;
        longint     start;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    longint     cyc      = 0;
    longint     busy_total = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (o_busy === 1'b1) busy_total <= busy_total + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input longint got, input longint lo, input longint hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, got, lo, hi, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (o_valid === 1'b1 || o_frameErr === 1'b1)) begin
            chk("strobe_exclusive", longint'(o_valid & o_frameErr), 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%0b frameErr=%0b data=0x%0h, nothing expected (t=%0t)",
                         o_valid, o_frameErr, o_data, $time);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind_frameErr", longint'(o_frameErr), longint'(e.is_err));
                chk("data", longint'(o_data), longint'(e.data));
                chk_range("latency", cyc - e.start, LAT - 1, LAT + 1);
`ifdef UART_RX_PARITY_EN
                chk("parityErr", longint'(o_parityErr), longint'(e.perr));
`endif
            end
        end
    end

    // Caller must be at a falling clock edge; returns at one too.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        exp_t e;
        e.start  = cyc;
        e.is_err = ~stop_bit;
        e.data   = stop_bit ? d : last_good;
        e.perr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        // Even parity: data ones plus parity bit must total an even count.
        e.perr   = stop_bit && (((($countones(d) + int'(par_bit)) % 2) == 0) == PODD);
`endif
        if (stop_bit) last_good = d;
        sb.push_back(e);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        repeat (DIV) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return logic'(($countones(d) % 2) != 0) ^ PODD;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint b0;
        logic [7:0] d;
        logic       sb_ok;
        logic       pb;
        int         gap;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", longint'(o_data), 0);
        chk("reset_valid", longint'(o_valid), 0);
        chk("reset_busy", longint'(o_busy), 0);
        chk("reset_frameErr", longint'(o_frameErr), 0);
        rst = 1'b0;
        idle(5);

        // 1: single 0xA5 frame, busy duration
        b0 = busy_total;
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        idle(DIV);
        chk_range("busy_cycles_A5", busy_total - b0, 150, 156);
        chk("data_A5_held", longint'(o_data), 8'hA5);

        // 2: back-to-back 0x00, 0xFF
        send_frame(8'h00, 1'b1, good_par(8'h00));
        send_frame(8'hFF, 1'b1, good_par(8'hFF));
        idle(DIV);
        chk("data_FF_held", longint'(o_data), 8'hFF);

        // 3: 4-cycle glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(10);
        chk("glitch_busy_clear", longint'(o_busy), 0);
        idle(DIV);

        // 4: frame error keeps previous data
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        idle(2 * DIV);
        chk("ferr_data_kept", longint'(o_data), 8'hFF);

        // 5: reset during bit 4 of 0x5A
        d  = 8'h5A;
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        rx = d[4];
        repeat (DIV / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_data", longint'(o_data), 0);
        chk("midreset_valid", longint'(o_valid), 0);
        chk("midreset_busy", longint'(o_busy), 0);
        chk("midreset_frameErr", longint'(o_frameErr), 0);
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3 * DIV);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        idle(DIV);
        chk("data_81_after_reset", longint'(o_data), 8'h81);

`ifdef UART_RX_PARITY_EN
        // 6: 0x07 with correct (1) and wrong (0) parity bit
        send_frame(8'h07, 1'b1, 1'b1);
        idle(DIV);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(DIV);
`endif

        // Randomised frames, glitches, stop errors and gaps
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                idle(24);
            end
            d     = 8'($urandom_range(0, 255));
            sb_ok = ($urandom_range(0, 4) != 0);
            pb    = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            send_frame(d, sb_ok, pb);
            if (!sb_ok) gap = DIV + int'($urandom_range(0, DIV));
            else if ($urandom_range(0, 1) == 0) gap = 0;
            else gap = int'($urandom_range(1, 40));
            if (gap > 0) idle(gap);
        end

        idle(4 * DIV);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        chk("final_busy", longint'(o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
